// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic light controller: the 3-bit phase
//   encodings driven on the state register, the one-hot lamp patterns
//   ({red,yellow,green}) and a legality helper for the state code.
package traffic_pkg;

    // Phase encodings, as stored by the downstream state register.
    localparam logic [2:0] S0 = 3'b000;  // A green,  B red
    localparam logic [2:0] S1 = 3'b001;  // A yellow, B red
    localparam logic [2:0] S2 = 3'b010;  // all red (A -> B handover)
    localparam logic [2:0] S3 = 3'b011;  // B green,  A red
    localparam logic [2:0] S4 = 3'b100;  // B yellow, A red
    localparam logic [2:0] S5 = 3'b101;  // all red (B -> A handover)

    // Lamp patterns, bit order {red,yellow,green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Codes 110/111 are never produced by the next-state logic; they can
    // only appear through upsets or a mis-loaded register.
    function automatic logic state_is_legal(input logic [2:0] st);
        return (st <= S5);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
//   Saturating phase dwell counter. Counts tick pulses since the last
//   clear and sticks at all-ones so a held green phase never wraps.
// Ports
//   clk   in  system clock, rising edge
//   reset in  synchronous, active-low reset (clears the count)
//   tick  in  one-cycle count-enable pulse
//   clr   in  clear request; wins over tick
//   cnt   out current count
module dwell_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/traffic_next_state.sv
// traffic_next_state
//   Next-state and lamp-decode stage of the traffic light controller.
//   The state register lives downstream; this block reads its output s,
//   times the current phase with a dwell counter advanced by the 1 Hz tick,
//   and returns the next state nxtS. The lamps are decoded from s.
// Ports
//   clk   in  system clock, rising edge
//   reset in  synchronous, active-low reset; forces nxtS to S0 while low
//   tick  in  one-cycle 1 Hz pulse from the clock divider
//   sa    in  car present on street A
//   sb    in  car present on street B
//   s     in  current registered state
//   nxtS  out next state for the state register
//   la    out street A lamps {red,yellow,green}
//   lb    out street B lamps {red,yellow,green}
module traffic_next_state
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sa,
    input  logic       sb,
    input  logic [2:0] s,
    output logic [2:0] nxtS,
    output logic [2:0] la,
    output logic [2:0] lb
);

    // Thresholds are compared one bit wider than the counter so that a
    // dwell of exactly 2^CNT_W ticks (threshold all-ones) stays exact.
    localparam logic [CNT_W:0] GREEN_M1  = (CNT_W+1)'(GREEN_MIN - 1);
    localparam logic [CNT_W:0] YELLOW_M1 = (CNT_W+1)'(YELLOW_T - 1);
    localparam logic [CNT_W:0] ALLRED_M1 = (CNT_W+1)'(ALLRED_T - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_x;
    logic             green_done;
    logic             yellow_done;
    logic             allred_done;
    logic [2:0]       next_s;
    logic             adv;

    // Any state change restarts the dwell, so the counter reads 0 in the
    // first cycle of every phase.
    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .clr   (adv),
        .cnt   (cnt)
    );

    assign cnt_x = {1'b0, cnt};

    // A phase of D ticks ends on the tick that would bring cnt to D.
    assign green_done  = tick && (cnt_x >= GREEN_M1);
    assign yellow_done = tick && (cnt_x >= YELLOW_M1);
    assign allred_done = tick && (cnt_x >= ALLRED_M1);

    always_comb begin
        next_s = s;
        case (s)
            // Leave green only if the other street wants it, or nobody is
            // waiting here; a car on A alone keeps A green indefinitely.
            S0: if (green_done && (sb || !sa)) next_s = S1;
            S1: if (yellow_done)               next_s = S2;
            S2: if (allred_done)               next_s = S3;
            S3: if (green_done && (sa || !sb)) next_s = S4;
            S4: if (yellow_done)               next_s = S5;
            S5: if (allred_done)               next_s = S0;
            // Illegal codes recover through the all-red phase at once.
            default:                           next_s = S5;
        endcase
    end

    // Holding reset steers the downstream register to S0.
    assign nxtS = reset ? next_s : S0;
    assign adv  = (nxtS != s);

    always_comb begin
        la = LAMP_RED;
        lb = LAMP_RED;
        if (state_is_legal(s)) begin
            case (s)
                S0:      la = LAMP_GRN;
                S1:      la = LAMP_YEL;
                S3:      lb = LAMP_GRN;
                S4:      lb = LAMP_YEL;
                default: begin
                    la = LAMP_RED;
                    lb = LAMP_RED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_next_state.sv
module tb_traffic_next_state;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       sa = 1'b1;
    logic       sb = 1'b0;
    logic [2:0] s;
    logic [2:0] nxtS, la, lb;
    logic [2:0] s_reg = 3'b111;
    logic       force_en = 1'b0;
    logic [2:0] s_force = 3'b000;
    logic [2:0] last_nxt;
    int         total = 0;
    int         bad = 0;

    // State after each tick of a full cycle with no cars.
    localparam logic [2:0] EXP_SEQ [18] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1,
        3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};

    always #5 clk = ~clk;

    // Downstream state register, closed around the DUT.
    always @(posedge clk) s_reg <= nxtS;
    assign s = force_en ? s_force : s_reg;

    traffic_next_state dut (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .sa   (sa),
        .sb   (sb),
        .s    (s),
        .nxtS (nxtS),
        .la   (la),
        .lb   (lb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One tick pulse spanning exactly one rising edge; nxtS seen during it.
    task automatic pulse();
        tick = 1'b1;
        #1;
        last_nxt = nxtS;
        clk_n(1);
        tick = 1'b0;
        #1;
    endtask

    initial begin
        // Reset with an illegal code on s: nxtS must still be S0.
        #3;
        chk("rst_nxt", 32'(nxtS), 32'h0);
        clk_n(2);
        chk("rst_cnt", 32'(dut.cnt), 32'h0);
        chk("rst_s", 32'(s), 32'h0);
        chk("rst_la", 32'(la), 32'h1);
        chk("rst_lb", 32'(lb), 32'h4);
        reset = 1'b1;

        // Green hold: car on A only, 20 ticks.
        for (int i = 0; i < 20; i++) begin
            pulse();
            chk("hold_nxt", 32'(last_nxt), 32'h0);
            chk("hold_la", 32'(la), 32'h1);
            chk("hold_lb", 32'(lb), 32'h4);
            clk_n(1);
        end
        chk("hold_sat", 32'(dut.cnt), 32'd15);

        // Car arrives on B: exit on the next tick.
        sb = 1'b1;
        pulse();
        chk("sb_nxt", 32'(last_nxt), 32'h1);
        chk("s1_cnt", 32'(dut.cnt), 32'h0);
        chk("s1_la", 32'(la), 32'h2);
        chk("s1_lb", 32'(lb), 32'h4);
        pulse();
        chk("s1_t1", 32'(last_nxt), 32'h1);
        pulse();
        chk("s1_t2", 32'(last_nxt), 32'h1);
        pulse();
        chk("s1_t3", 32'(last_nxt), 32'h2);
        chk("s2_la", 32'(la), 32'h4);
        chk("s2_lb", 32'(lb), 32'h4);
        pulse();
        chk("s2_t1", 32'(last_nxt), 32'h3);
        chk("s3_la", 32'(la), 32'h4);
        chk("s3_lb", 32'(lb), 32'h1);

        // Full cycle with no cars from reset.
        reset = 1'b0;
        sa = 1'b0;
        sb = 1'b0;
        clk_n(1);
        reset = 1'b1;
        chk("cyc_s0", 32'(s), 32'h0);
        chk("cyc_cnt0", 32'(dut.cnt), 32'h0);
        for (int i = 0; i < 18; i++) begin
            pulse();
            chk($sformatf("cyc_t%0d", i + 1), 32'(s), 32'(EXP_SEQ[i]));
            clk_n(1);
        end

        // Walk to S4 (14 ticks), then one tick inside it.
        repeat (14) pulse();
        chk("s4_s", 32'(s), 32'h4);
        chk("s4_la", 32'(la), 32'h4);
        chk("s4_lb", 32'(lb), 32'h2);
        pulse();
        chk("s4_cnt1", 32'(dut.cnt), 32'h1);

        // No ticks for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            chk("idle_nxt", 32'(nxtS), 32'h4);
            clk_n(1);
        end
        chk("idle_cnt", 32'(dut.cnt), 32'h1);

        // Illegal code: immediate recovery to S5, no tick needed.
        force_en = 1'b1;
        s_force = 3'b111;
        #1;
        chk("ill7_nxt", 32'(nxtS), 32'h5);
        chk("ill7_la", 32'(la), 32'h4);
        chk("ill7_lb", 32'(lb), 32'h4);
        s_force = 3'b110;
        #1;
        chk("ill6_nxt", 32'(nxtS), 32'h5);
        clk_n(1);
        chk("ill_cnt", 32'(dut.cnt), 32'h0);
        force_en = 1'b0;
        #1;
        chk("ill_sreg", 32'(s), 32'h5);
        chk("s5_la", 32'(la), 32'h4);
        chk("s5_lb", 32'(lb), 32'h4);
        pulse();
        chk("s5_exit", 32'(last_nxt), 32'h0);

        // Reset in the middle of S1.
        repeat (5) pulse();
        chk("mid_s1", 32'(s), 32'h1);
        pulse();
        pulse();
        chk("mid_cnt2", 32'(dut.cnt), 32'h2);
        reset = 1'b0;
        #1;
        chk("mid_rst_nxt", 32'(nxtS), 32'h0);
        clk_n(1);
        chk("mid_rst_cnt", 32'(dut.cnt), 32'h0);
        chk("mid_rst_s", 32'(s), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse();
            chk($sformatf("fresh_t%0d", i + 1), 32'(last_nxt), 32'h0);
        end
        pulse();
        chk("fresh_t5", 32'(last_nxt), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
